// File: rtl/timer_irq_ctrl_pkg.sv
// Shared types and constants for the timer interrupt slice.
// Also used by the register block for CTRL bit positions.
package timer_pkg;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PULSE
    } irq_state_t;

    localparam int CNT_W_DEF   = 32;
    localparam int MISS_W_DEF  = 8;
    localparam int PULSE_W_DEF = 4;
    localparam int PCNT_W      = 8;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT     = 1;
    localparam int CTRL_PULSE_MODE_BIT = 2;

endpackage

// File: rtl/timer_irq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the count at one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Terminal-count detection, sticky W1C status, masked level/pulse irq
// and a saturating count of events lost while status was pending.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MISS_W  = MISS_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  count,
    input  logic              irq_en,
    input  logic              pulse_mode,
    input  logic              status_clr,
    input  logic              missed_clr,
    output logic              tc_event,
    output logic              raw_status,
    output logic              irq,
    output logic [MISS_W-1:0] missed_cnt
);

    localparam logic [PCNT_W-1:0] PLOAD = PCNT_W'(PULSE_W - 1);

    logic              prev_nz;
    logic              mode_q;
    logic              ev;
    logic              raw_n;
    logic              miss_inc;
    logic              irq_n;
    irq_state_t        state_q;
    irq_state_t        state_n;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_n;

    // prev_nz suppresses events when the count was already zero
    assign ev       = enable & prev_nz & (count == '0);
    assign miss_inc = ev & raw_status & ~status_clr;

    always_comb begin
        raw_n = raw_status;
        if (ev) begin
            raw_n = 1'b1;
        end else if (status_clr) begin
            raw_n = 1'b0;
        end
    end

    always_comb begin
        state_n = IRQ_IDLE;
        pcnt_n  = '0;
        irq_n   = 1'b0;
        if (!pulse_mode) begin
            irq_n = raw_n & irq_en;
        end else if (pulse_mode == mode_q) begin
            unique case (state_q)
                IRQ_IDLE: begin
                    if (ev && irq_en) begin
                        state_n = IRQ_PULSE;
                        pcnt_n  = PLOAD;
                        irq_n   = 1'b1;
                    end
                end
                IRQ_PULSE: begin
                    if (!irq_en) begin
                        state_n = IRQ_IDLE;
                    end else if (ev) begin
                        state_n = IRQ_PULSE;
                        pcnt_n  = PLOAD;
                        irq_n   = 1'b1;
                    end else if (pcnt_q != '0) begin
                        state_n = IRQ_PULSE;
                        pcnt_n  = pcnt_q - PCNT_W'(1);
                        irq_n   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_nz    <= 1'b0;
            mode_q     <= 1'b0;
            tc_event   <= 1'b0;
            raw_status <= 1'b0;
            irq        <= 1'b0;
            state_q    <= IRQ_IDLE;
            pcnt_q     <= '0;
        end else begin
            prev_nz    <= (count != '0);
            mode_q     <= pulse_mode;
            tc_event   <= ev;
            raw_status <= raw_n;
            irq        <= irq_n;
            state_q    <= state_n;
            pcnt_q     <= pcnt_n;
        end
    end

    sat_counter #(
        .W(MISS_W)
    ) u_missed (
        .clk(clk),
        .rst(rst),
        .clr(missed_clr),
        .inc(miss_inc),
        .cnt(missed_cnt)
    );

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed vector table plus randomized run against a behavioural model.
module tb_timer_irq_ctrl;

    localparam int CNT_W   = 8;
    localparam int MISS_W  = 2;
    localparam int PULSE_W = 4;
    localparam int MMAX    = (1 << MISS_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [CNT_W-1:0]  count;
    logic              irq_en;
    logic              pulse_mode;
    logic              status_clr;
    logic              missed_clr;
    logic              tc_event;
    logic              raw_status;
    logic              irq;
    logic [MISS_W-1:0] missed_cnt;

    timer_irq_ctrl #(
        .CNT_W(CNT_W),
        .MISS_W(MISS_W),
        .PULSE_W(PULSE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .count(count),
        .irq_en(irq_en),
        .pulse_mode(pulse_mode),
        .status_clr(status_clr),
        .missed_clr(missed_clr),
        .tc_event(tc_event),
        .raw_status(raw_status),
        .irq(irq),
        .missed_cnt(missed_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, e;
        int   c;
        logic ie, pm, sc, mc;
        logic tc, raw, irq;
        int   miss;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // behavioural model: irq in pulse mode is "cycles of high time left"
    logic m_prev_nz, m_mode, m_raw, m_tc, m_irq;
    int   m_left, m_miss;

    function automatic void add(input logic r, input logic e, input int c,
                                input logic ie, input logic pm,
                                input logic sc, input logic mc,
                                input logic tc, input logic raw,
                                input logic ir, input int miss);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.ie = ie; v.pm = pm;
        v.sc = sc; v.mc = mc; v.tc = tc; v.raw = raw;
        v.irq = ir; v.miss = miss;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic tc, input logic raw,
                         input logic ir, input int miss);
        n_vec++;
        if (tc_event !== tc || raw_status !== raw || irq !== ir ||
            int'(missed_cnt) !== miss) begin
            n_err++;
            $display("FAIL %s: got tc=%b raw=%b irq=%b miss=%0d, want tc=%b raw=%b irq=%b miss=%0d",
                     nm, tc_event, raw_status, irq, missed_cnt,
                     tc, raw, ir, miss);
        end
    endtask

    task automatic model_step();
        logic ev, inc, raw_n;
        if (rst) begin
            m_prev_nz = 0; m_mode = 0; m_raw = 0; m_tc = 0;
            m_irq = 0; m_left = 0; m_miss = 0;
            return;
        end
        ev    = enable && m_prev_nz && (count == 0);
        inc   = ev && m_raw && !status_clr;
        raw_n = ev ? 1'b1 : (status_clr ? 1'b0 : m_raw);
        if (missed_clr) m_miss = inc ? 1 : 0;
        else if (inc && m_miss < MMAX) m_miss = m_miss + 1;
        if (pulse_mode) begin
            if (pulse_mode != m_mode || !irq_en) m_left = 0;
            else if (ev) m_left = PULSE_W;
            else if (m_left > 0) m_left = m_left - 1;
            m_irq = (m_left > 0);
        end else begin
            m_left = 0;
            m_irq  = raw_n && irq_en;
        end
        m_tc      = ev;
        m_raw     = raw_n;
        m_prev_nz = (count != 0);
        m_mode    = pulse_mode;
    endtask

    initial begin
        rst = 1; enable = 0; count = '0; irq_en = 0;
        pulse_mode = 0; status_clr = 0; missed_clr = 0;

        // level mode, single event then W1C
        add(1,0,2,0,0,0,0, 0,0,0,0);
        add(0,1,2,1,0,0,0, 0,0,0,0);
        add(0,1,1,1,0,0,0, 0,0,0,0);
        add(0,1,0,1,0,0,0, 1,1,1,0);
        add(0,1,0,1,0,0,0, 0,1,1,0);
        add(0,1,0,1,0,0,0, 0,1,1,0);
        add(0,1,0,1,0,1,0, 0,0,0,0);
        add(0,1,0,1,0,0,0, 0,0,0,0);
        // count parked at zero, then a disabled countdown
        add(1,0,0,1,0,0,0, 0,0,0,0);
        for (int i = 0; i < 10; i++) add(0,1,0,1,0,0,0, 0,0,0,0);
        add(0,0,1,1,0,0,0, 0,0,0,0);
        add(0,0,0,1,0,0,0, 0,0,0,0);
        add(0,1,0,1,0,0,0, 0,0,0,0);
        // missed events with 2-bit saturation
        add(1,0,0,1,0,0,0, 0,0,0,0);
        add(0,1,1,1,0,0,0, 0,0,0,0);
        add(0,1,0,1,0,0,0, 1,1,1,0);
        for (int i = 0; i < 5; i++) begin
            add(0,1,1,1,0,0,0, 0,1,1,(i < 3) ? i : 3);
            add(0,1,0,1,0,0,0, 1,1,1,(i < 3) ? i + 1 : 3);
        end
        add(0,1,1,1,0,0,0, 0,1,1,3);
        add(0,1,0,1,0,0,1, 1,1,1,1);
        // clear colliding with an event
        add(0,1,1,1,0,0,0, 0,1,1,1);
        add(0,1,0,1,0,1,0, 1,1,1,1);
        add(0,1,1,1,0,1,0, 0,0,0,1);
        add(0,1,1,1,0,0,1, 0,0,0,0);
        // masked event, then unmask
        add(1,0,0,0,0,0,0, 0,0,0,0);
        add(0,1,1,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0,0, 1,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,0,0);
        add(0,1,0,1,0,0,0, 0,1,1,0);
        add(0,1,0,0,0,0,0, 0,1,0,0);
        // pulse mode single event: four cycles high
        add(1,0,0,1,1,0,0, 0,0,0,0);
        add(0,1,1,1,1,0,0, 0,0,0,0);
        add(0,1,0,1,1,0,0, 1,1,1,0);
        add(0,1,5,1,1,0,0, 0,1,1,0);
        add(0,1,5,1,1,0,0, 0,1,1,0);
        add(0,1,5,1,1,0,0, 0,1,1,0);
        add(0,1,5,1,1,0,0, 0,1,0,0);
        add(0,1,5,1,1,0,0, 0,1,0,0);
        // pulse retrigger: six cycles high
        add(1,0,0,1,1,0,0, 0,0,0,0);
        add(0,1,1,1,1,0,0, 0,0,0,0);
        add(0,1,0,1,1,0,0, 1,1,1,0);
        add(0,1,1,1,1,0,0, 0,1,1,0);
        add(0,1,0,1,1,0,0, 1,1,1,1);
        add(0,1,1,1,1,0,0, 0,1,1,1);
        add(0,1,1,1,1,0,0, 0,1,1,1);
        add(0,1,1,1,1,0,0, 0,1,1,1);
        add(0,1,1,1,1,0,0, 0,1,0,1);
        // mask drop mid-pulse
        add(1,0,0,1,1,0,0, 0,0,0,0);
        add(0,1,1,1,1,0,0, 0,0,0,0);
        add(0,1,0,1,1,0,0, 1,1,1,0);
        add(0,1,5,1,1,0,0, 0,1,1,0);
        add(0,1,5,0,1,0,0, 0,1,0,0);
        add(0,1,5,0,1,0,0, 0,1,0,0);
        // reset mid-pulse
        add(1,0,0,1,1,0,0, 0,0,0,0);
        add(0,1,1,1,1,0,0, 0,0,0,0);
        add(0,1,0,1,1,0,0, 1,1,1,0);
        add(1,1,5,1,1,0,0, 0,0,0,0);

        foreach (tbl[i]) begin
            rst = tbl[i].r; enable = tbl[i].e; count = CNT_W'(tbl[i].c);
            irq_en = tbl[i].ie; pulse_mode = tbl[i].pm;
            status_clr = tbl[i].sc; missed_clr = tbl[i].mc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].tc, tbl[i].raw,
                  tbl[i].irq, tbl[i].miss);
        end

        for (int i = 0; i < 3000; i++) begin
            rst        = (i == 0) || ($urandom_range(0, 149) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            count      = CNT_W'($urandom_range(0, 3));
            irq_en     = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 59) == 0) pulse_mode = ~pulse_mode;
            status_clr = ($urandom_range(0, 9) == 0);
            missed_clr = ($urandom_range(0, 19) == 0);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d", i), m_tc, m_raw, m_irq, m_miss);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Interrupt stage directly downstream of the down-counting timer.
- Watches the timer's count and enable, and detects each terminal-count event (count falls to zero).
- Holds a sticky raw status bit with write-1-to-clear semantics, applies the interrupt mask, and drives the peripheral's irq line in level or pulse mode.
- Counts events that arrive while status is still pending (missed interrupts).

Parameters:
- CNT_W, 32, width of the timer count input
- MISS_W, 8, width of the saturating missed-event counter
- PULSE_W, 4, irq high time in cycles in pulse mode (legal range 1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  timer enable (same CTRL bit that drives the timer)
- count  in  CNT_W  current timer count
- irq_en  in  1  interrupt mask; 1 = irq allowed
- pulse_mode  in  1  0 = level irq, 1 = pulsed irq
- status_clr  in  1  one-cycle W1C strobe for raw_status
- missed_clr  in  1  one-cycle strobe clearing missed_cnt
- tc_event  out  1  one-cycle flag per detected terminal count
- raw_status  out  1  sticky unmasked pending bit
- irq  out  1  interrupt request to the system
- missed_cnt  out  MISS_W  events lost while raw_status was set

Behaviour:
- All state is updated on posedge clk. The synchronous rst takes priority over every other input.
- Reset values: tc_event=0, raw_status=0, irq=0, missed_cnt=0, prev_nz=0, FSM=IDLE, pulse counter=0.
- prev_nz (internal flop) <= (count != 0) on every cycle, regardless of enable.
- Event condition (combinational): ev = enable & prev_nz & (count == 0).
  - Count starting at 0 after reset or while the load value is 0 produces no event.
  - Counts while disabled produce no event.
- Latency: count==0 is sampled at edge N; tc_event, raw_status and irq (level mode) are visible after edge N, i.e. 1 cycle of latency.
- tc_event <= ev; it is high for exactly one cycle per event.
- raw_status next-state rules:
  - ev=1 -> 1. An event wins over a simultaneous status_clr.
  - else status_clr=1 -> 0.
  - else hold.
- missed_cnt rules:
  - Increments when ev=1, raw_status=1 and status_clr=0.
  - Saturates at 2^MISS_W-1 and never wraps.
  - missed_clr sets it to 0; if an increment occurs in the same cycle, the result is 1.
- Level mode (pulse_mode=0): irq <= next_raw_status & irq_en.
  - Masking or unmasking takes effect at the next edge.
  - Unmasking while a pending status exists raises irq.
- Pulse mode (pulse_mode=1), FSM with states IDLE and PULSE:
  - IDLE -> PULSE when ev & irq_en. Load pulse counter = PULSE_W-1 and set irq <= 1.
  - In PULSE: if ev & irq_en, reload the counter (retrigger) and keep irq high. Else if counter == 0, go to IDLE and set irq <= 0. Else decrement the counter.
  - irq_en dropping during PULSE forces IDLE and irq <= 0 at the next edge.
  - Pulse mode does not react to status_clr. raw_status and missed_cnt behave identically in both modes.
- Changing pulse_mode forces the FSM to IDLE. irq then follows the newly selected mode from the next edge.
- rst asserted mid-pulse or mid-pending clears everything at that edge. No event is detected on the first cycle after rst deasserts, because prev_nz=0.

Decomposition:
- Shared package timer_pkg holds:
  - the FSM state enum irq_state_t {IRQ_IDLE, IRQ_PULSE}
  - localparams for default CNT_W, MISS_W, PULSE_W
  - the CTRL bit positions for enable, irq_en and pulse_mode, also used by the register block
- One natural sub-module: sat_counter (MISS_W-bit saturating up-counter with clear and increment inputs), instantiated for missed_cnt.

Test Plan:
- Single event, level mode: enable=1, irq_en=1, count steps 2,1,0 -> tc_event high for 1 cycle after count==0 is sampled, raw_status=1, irq=1. Pulse status_clr 3 cycles later -> raw_status=0 and irq=0 at the next edge; missed_cnt=0.
- No spurious events: after rst, enable=1 with count held at 0 for 10 cycles -> tc_event, raw_status and irq all stay 0. Then count 1 -> 0 with enable=0 -> still no event.
- Missed events and saturation: MISS_W=2, raw_status left set, 5 further events -> missed_cnt reads 1,2,3,3,3. missed_clr in the same cycle as a 6th event -> missed_cnt=1.
- Clear/event collision: status_clr asserted in the same cycle ev fires with raw_status=1 -> raw_status stays 1 and missed_cnt is unchanged.
- Pulse mode: PULSE_W=4, single event -> irq high for exactly 4 cycles then 0, while raw_status stays 1. A second event in the 3rd pulse cycle -> irq is extended to 4 cycles after the retrigger, 6 total. irq_en=0 mid-pulse -> irq=0 at the next edge.
- Mask and reset: event with irq_en=0 -> raw_status=1, irq=0. Setting irq_en=1 (level mode) -> irq=1 next cycle. Asserting rst during an active pulse -> all outputs 0 at that edge.
